// File: rtl/counter_event_monitor.sv
// Event monitor for an up/down counter: detects overflow/underflow wraps,
// keeps saturating tallies, measures the overflow-to-overflow period and
// raises sticky acknowledge-cleared interrupts per event class.
module counter_event_monitor #(
    parameter int WIDTH = 4,
    parameter int EVT_W = 8,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             max_in,
    input  logic             zero_in,
    input  logic             ce_in,
    input  logic             up_in,
    input  logic             clear,
    input  logic [1:0]       irq_en,
    input  logic [1:0]       irq_ack,
    output logic [EVT_W-1:0] ovf_cnt,
    output logic [EVT_W-1:0] unf_cnt,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             period_sat,
    output logic [1:0]       irq_src,
    output logic             irq
);

    localparam logic [EVT_W-1:0] EVT_MAX  = '1;
    localparam logic [PER_W-1:0] PER_MAX  = '1;
    localparam logic [PER_W-1:0] PER_NEAR = PER_MAX - PER_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic prev_max;
    logic prev_zero;
    logic prev_ce;
    logic prev_up;

    logic ovf_evt;
    logic unf_evt;
    logic measure;

    logic [PER_W-1:0] timer;
    logic             sat_flag;
    logic [1:0]       irq_src_next;

    // Saturating increment for the event tallies.
    function automatic logic [EVT_W-1:0] evt_inc(input logic [EVT_W-1:0] v);
        return (v == EVT_MAX) ? v : v + EVT_W'(1);
    endfunction

    // Saturating increment for the period timer.
    function automatic logic [PER_W-1:0] per_inc(input logic [PER_W-1:0] v);
        return (v == PER_MAX) ? v : v + PER_W'(1);
    endfunction

    // Sample the counter status/control of the previous cycle; keeps updating during clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_max  <= 1'b0;
            prev_zero <= 1'b0;
            prev_ce   <= 1'b0;
            prev_up   <= 1'b0;
        end else begin
            prev_max  <= max_in;
            prev_zero <= zero_in;
            prev_ce   <= ce_in;
            prev_up   <= up_in;
        end
    end

    // Wrap detection: an enabled count step from max to zero (up) or zero to max (down).
    always_comb begin
        ovf_evt = prev_max & prev_ce & prev_up & zero_in;
        unf_evt = prev_zero & prev_ce & ~prev_up & max_in;
    end

    // Saturating overflow/underflow tallies.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (ovf_evt) ovf_cnt <= evt_inc(ovf_cnt);
            if (unf_evt) unf_cnt <= evt_inc(unf_cnt);
        end
    end

    // Period FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Period FSM next state; the first overflow only arms, later ones measure.
    always_comb begin
        state_next = state;
        measure    = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (ovf_evt) state_next = ARMED;
                ARMED:   if (ovf_evt) measure = 1'b1;
                default: state_next = IDLE;
            endcase
        end
    end

    // Period timer: counts cycles since the last overflow; sat_flag marks it pinned at max.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer    <= '0;
            sat_flag <= 1'b0;
        end else if (state == IDLE) begin
            timer    <= ovf_evt ? PER_W'(1) : '0;
            sat_flag <= 1'b0;
        end else if (ovf_evt) begin
            timer    <= PER_W'(1);
            sat_flag <= 1'b0;
        end else begin
            timer    <= per_inc(timer);
            sat_flag <= sat_flag | (timer >= PER_NEAR);
        end
    end

    // Period result and its one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            period       <= '0;
            period_sat   <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= measure;
            if (measure) begin
                period     <= timer;
                period_sat <= sat_flag;
            end
        end
    end

    // Sticky interrupt sources: a new set wins over a simultaneous acknowledge.
    always_comb begin
        irq_src_next    = irq_src & ~irq_ack;
        irq_src_next[0] = irq_src_next[0] | (ovf_evt & irq_en[0]);
        irq_src_next[1] = irq_src_next[1] | (unf_evt & irq_en[1]);
    end

    // Interrupt source register and combined request.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            irq_src <= 2'b00;
            irq     <= 1'b0;
        end else begin
            irq_src <= irq_src_next;
            irq     <= |irq_src_next;
        end
    end

    // Counter status flags must agree with the counter value.
    a_max_consistent: assert property (@(posedge clk) disable iff (rst)
        max_in |-> (count_in == {WIDTH{1'b1}}));
    a_zero_consistent: assert property (@(posedge clk) disable iff (rst)
        zero_in |-> (count_in == {WIDTH{1'b0}}));

endmodule

// File: tb/tb_counter_event_monitor.sv
// Bench for counter_event_monitor: a cycle-accurate model driven from a
// simulated up/down counter, compared every cycle against two instances
// (PER_W=16 and PER_W=4), plus literal expectations at key points.
module tb_counter_event_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       max_in = 1'b0;
    logic       zero_in = 1'b1;
    logic       ce_in = 1'b0;
    logic       up_in = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] irq_en = 2'b00;
    logic [1:0] irq_ack = 2'b00;

    logic [7:0]  ovf_cnt, unf_cnt;
    logic [15:0] period;
    logic        period_valid, period_sat, irq;
    logic [1:0]  irq_src;

    logic [7:0]  b_ovf_cnt, b_unf_cnt;
    logic [3:0]  b_period;
    logic        b_period_valid, b_period_sat, b_irq;
    logic [1:0]  b_irq_src;

    counter_event_monitor #(.WIDTH(4), .EVT_W(8), .PER_W(16)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .max_in(max_in),
        .zero_in(zero_in), .ce_in(ce_in), .up_in(up_in), .clear(clear),
        .irq_en(irq_en), .irq_ack(irq_ack), .ovf_cnt(ovf_cnt),
        .unf_cnt(unf_cnt), .period(period), .period_valid(period_valid),
        .period_sat(period_sat), .irq_src(irq_src), .irq(irq)
    );

    counter_event_monitor #(.WIDTH(4), .EVT_W(8), .PER_W(4)) dut4 (
        .clk(clk), .rst(rst), .count_in(count_in), .max_in(max_in),
        .zero_in(zero_in), .ce_in(ce_in), .up_in(up_in), .clear(clear),
        .irq_en(irq_en), .irq_ack(irq_ack), .ovf_cnt(b_ovf_cnt),
        .unf_cnt(b_unf_cnt), .period(b_period), .period_valid(b_period_valid),
        .period_sat(b_period_sat), .irq_src(b_irq_src), .irq(b_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counter history as seen one cycle ago, overflow timestamps, tallies.
    bit       h_max, h_zero, h_ce, h_up;
    int       now = 0;
    int       last_ovf = 0;
    bit       armed = 1'b0;
    int       m_ovf = 0, m_unf = 0;
    int       m_per16 = 0, m_per4 = 0;
    bit       m_sat16 = 0, m_sat4 = 0, m_valid = 0;
    bit [1:0] m_src = 2'b00;

    always @(posedge clk) begin
        bit ovf, unf;
        int el;
        if (rst) begin
            {h_max, h_zero, h_ce, h_up} = 4'b0000;
            armed = 0; m_ovf = 0; m_unf = 0;
            m_per16 = 0; m_per4 = 0; m_sat16 = 0; m_sat4 = 0; m_valid = 0;
            m_src = 2'b00;
        end else begin
            ovf = h_max && h_ce && h_up && zero_in;
            unf = h_zero && h_ce && !h_up && max_in;
            m_valid = 0;
            if (clear) begin
                armed = 0; m_ovf = 0; m_unf = 0;
                m_per16 = 0; m_per4 = 0; m_sat16 = 0; m_sat4 = 0;
                m_src = 2'b00;
            end else begin
                if (ovf) begin
                    if (m_ovf < 255) m_ovf++;
                    if (armed) begin
                        el = now - last_ovf;
                        m_per16 = (el > 65535) ? 65535 : el;
                        m_sat16 = (el >= 65535);
                        m_per4  = (el > 15) ? 15 : el;
                        m_sat4  = (el >= 15);
                        m_valid = 1;
                    end
                    armed = 1;
                    last_ovf = now;
                end
                if (unf && m_unf < 255) m_unf++;
                for (int i = 0; i < 2; i++) begin
                    if (irq_ack[i]) m_src[i] = 1'b0;
                end
                if (ovf && irq_en[0]) m_src[0] = 1'b1;
                if (unf && irq_en[1]) m_src[1] = 1'b1;
            end
            h_max = max_in; h_zero = zero_in; h_ce = ce_in; h_up = up_in;
        end
        now++;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            chk("unf_cnt", 32'(unf_cnt), 32'(m_unf));
            chk("period", 32'(period), 32'(m_per16));
            chk("period_sat", 32'(period_sat), 32'(m_sat16));
            chk("period_valid", 32'(period_valid), 32'(m_valid));
            chk("irq_src", 32'(irq_src), 32'(m_src));
            chk("irq", 32'(irq), 32'(|m_src));
            chk("p4_ovf_cnt", 32'(b_ovf_cnt), 32'(m_ovf));
            chk("p4_period", 32'(b_period), 32'(m_per4));
            chk("p4_period_sat", 32'(b_period_sat), 32'(m_sat4));
            chk("p4_period_valid", 32'(b_period_valid), 32'(m_valid));
            chk("p4_irq_src", 32'(b_irq_src), 32'(m_src));
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] cnt = 4'd0;

    // Present the counter state for one cycle, then advance the counter if enabled.
    task automatic cyc(input logic ce, input logic up);
        ce_in = ce; up_in = up; count_in = cnt;
        max_in = (cnt == 4'hF); zero_in = (cnt == 4'h0);
        @(posedge clk); #1;
        if (ce) cnt = up ? cnt + 4'd1 : cnt - 4'd1;
    endtask

    task automatic run_up_until_valid(input int maxc, input string name);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc(1'b1, 1'b1);
            if (period_valid === 1'b1) seen = 1;
        end
        chk({name, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_up_until_first_ovf(input int maxc, input string name);
        bit got = 0, vseen = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            cyc(1'b1, 1'b1);
            if (period_valid === 1'b1) vseen = 1;
            if (ovf_cnt !== 8'd0) got = 1;
        end
        chk({name, "_ovf_seen"}, 32'(got), 32'd1);
        chk({name, "_no_valid"}, 32'(vseen), 32'd0);
        chk({name, "_ovf_cnt"}, 32'(ovf_cnt), 32'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ovf"}, 32'(ovf_cnt), 32'd0);
        chk({name, "_unf"}, 32'(unf_cnt), 32'd0);
        chk({name, "_period"}, 32'(period), 32'd0);
        chk({name, "_valid"}, 32'(period_valid), 32'd0);
        chk({name, "_sat"}, 32'(period_sat), 32'd0);
        chk({name, "_src"}, 32'(irq_src), 32'd0);
        chk({name, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        int saved;
        // Reset
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_all_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Continuous up count: first overflow arms only, second measures 16
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1);
        chk("first_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("first_no_valid", 32'(period_valid), 32'd0);
        chk("first_period", 32'(period), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1);
        chk("second_valid", 32'(period_valid), 32'd1);
        chk("second_period", 32'(period), 32'd16);
        chk("second_sat", 32'(period_sat), 32'd0);
        chk("second_p4_period", 32'(b_period), 32'd15);
        chk("second_p4_sat", 32'(b_period_sat), 32'd1);
        cyc(1'b1, 1'b1);
        chk("valid_pulse_ends", 32'(period_valid), 32'd0);
        chk("period_holds", 32'(period), 32'd16);
        chk("model_ovf_pin", 32'(m_ovf), 32'd2);

        // Up count with ce every other cycle
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        chk("half_rate_period", 32'(period), 32'd32);
        chk("half_rate_unf", 32'(unf_cnt), 32'd0);

        // Down count from 0 with underflow interrupt enabled
        irq_en = 2'b10;
        cnt = 4'd0;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("unf_first_cnt", 32'(unf_cnt), 32'd1);
        chk("unf_irq_src", 32'(irq_src), 32'd2);
        chk("unf_irq", 32'(irq), 32'd1);
        irq_ack = 2'b10;
        cyc(1'b1, 1'b0);
        irq_ack = 2'b00;
        chk("ack_clears_src", 32'(irq_src), 32'd0);
        chk("ack_clears_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0);
        irq_ack = 2'b10;
        cyc(1'b1, 1'b0);
        irq_ack = 2'b00;
        chk("set_beats_ack_cnt", 32'(unf_cnt), 32'd2);
        chk("set_beats_ack_src", 32'(irq_src), 32'd2);
        chk("set_beats_ack_irq", 32'(irq), 32'd1);

        // Loads with ce=0 are not events
        irq_en = 2'b00;
        saved = m_ovf;
        cnt = 4'hF; cyc(1'b0, 1'b1);
        cnt = 4'h0; cyc(1'b0, 1'b1);
        chk("load_no_event", 32'(ovf_cnt), 32'(saved));

        // 300 overflows saturate the tally; masked enable keeps the sticky bit
        for (int i = 0; i < 300 * 16 + 2; i++) cyc(1'b1, 1'b1);
        chk("ovf_saturated", 32'(ovf_cnt), 32'd255);
        chk("mask_keeps_src", 32'(irq_src), 32'd2);
        chk("unf_after_up", 32'(unf_cnt), 32'd2);

        // Stall 20 cycles while armed: 36-cycle period, PER_W=4 saturates
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        run_up_until_valid(40, "stall");
        chk("stall_period", 32'(period), 32'd36);
        chk("stall_sat", 32'(period_sat), 32'd0);
        chk("stall_p4_period", 32'(b_period), 32'd15);
        chk("stall_p4_sat", 32'(b_period_sat), 32'd1);

        // Clear mid-measurement
        clear = 1'b1;
        cyc(1'b1, 1'b1);
        clear = 1'b0;
        chk_all_zero("clear");
        irq_en = 2'b01;
        run_up_until_first_ovf(40, "post_clear");
        chk("post_clear_src", 32'(irq_src), 32'd1);
        chk("post_clear_irq", 32'(irq), 32'd1);
        run_up_until_valid(40, "post_clear");
        chk("post_clear_period", 32'(period), 32'd16);

        // Reset mid-measurement
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        chk_all_zero("mid_reset");
        run_up_until_first_ovf(40, "post_reset");

        cyc(1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
